// File: rtl/clock_divider_multi_if.sv
// Control and status bundle for clock_divider_multi.
// master: the side that drives enables, loads and restarts.
// slave: the divider itself.
interface clock_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 28
);
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] load;
  logic [CNT_W-1:0]  div_in;
  logic              sync_restart;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] pending;

  modport master (
    output enable, load, div_in, sync_restart,
    input  tick, clk_out, pending
  );

  modport slave (
    input  enable, load, div_in, sync_restart,
    output tick, clk_out, pending
  );
endinterface

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider.
// Each channel divides the system clock by a runtime-loadable divisor and
// produces a one-cycle tick enable and a divided square wave. A divisor
// loaded while a channel runs is held in a shadow register until the end of
// the current period, so periods are never cut short.
// Optional macro CLKDIV_REGOUT_EN: registers tick/clk_out (one-cycle lag,
// glitch-free). Without it, the outputs are a combinational decode of state.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  clock_divider_multi_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic             RST_CLK = (DEFAULT_DIV >= 2) ? 1'b0 : 1'b1;

  // A divisor of zero is meaningless; treat it as divide-by-one.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  logic [CNT_W-1:0] w_div_ld;
  assign w_div_ld = clamp_div(bus.div_in);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend;
    logic             w_wrap;
    logic             w_tick;
    logic             w_clk;

    assign w_wrap = (r_cnt == r_div_act - CNT_W'(1));
    assign w_tick = bus.enable[gi] & w_wrap;
    assign w_clk  = (r_cnt < (r_div_act >> 1)) ? 1'b0 : 1'b1;

    // Counter and divisor update; earlier branches take priority.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_cnt      <= '0;
        r_div_act  <= DEF_DIV;
        r_div_pend <= DEF_DIV;
        r_pend     <= 1'b0;
      end else if (bus.sync_restart) begin
        r_cnt <= '0;
        if (bus.load[gi]) begin
          r_div_act <= w_div_ld;
        end else if (r_pend) begin
          r_div_act <= r_div_pend;
        end
        r_pend <= 1'b0;
      end else if (bus.load[gi] && !bus.enable[gi]) begin
        // Stopped channel: nothing to protect, apply at once.
        r_div_act <= w_div_ld;
        r_cnt     <= '0;
        r_pend    <= 1'b0;
      end else if (bus.load[gi] && w_wrap) begin
        r_cnt     <= '0;
        r_div_act <= w_div_ld;
        r_pend    <= 1'b0;
      end else if (bus.load[gi]) begin
        // Running mid-period: park the divisor until the wrap.
        r_div_pend <= w_div_ld;
        r_pend     <= 1'b1;
        r_cnt      <= r_cnt + CNT_W'(1);
      end else if (bus.enable[gi] && w_wrap) begin
        r_cnt <= '0;
        if (r_pend) begin
          r_div_act <= r_div_pend;
          r_pend    <= 1'b0;
        end
      end else if (bus.enable[gi]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

`ifdef CLKDIV_REGOUT_EN
    logic r_tick;
    logic r_clk;

    // Flop the decoded outputs so they can safely clock downstream logic.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_tick <= 1'b0;
        r_clk  <= RST_CLK;
      end else begin
        r_tick <= w_tick;
        r_clk  <= w_clk;
      end
    end

    assign bus.tick[gi]    = r_tick;
    assign bus.clk_out[gi] = r_clk;
`else
    assign bus.tick[gi]    = w_tick;
    assign bus.clk_out[gi] = w_clk;
`endif

    assign bus.pending[gi] = r_pend;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (4 channels, 4-bit divisors).
module tb_clock_divider_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
`ifdef CLKDIV_REGOUT_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  clock_divider_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clock_divider_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge (one rising edge has passed).
  task automatic nxt;
    @(negedge clock);
    #1;
  endtask

  logic [10:0] t3_tick, t3_clk, t3_pend;

  initial begin
    t3_tick = 11'b010_0000_1000;
    t3_clk  = 11'b011_1000_1100;
    t3_pend = 11'b000_0000_1100;

    bus.enable       = '0;
    bus.load         = '0;
    bus.div_in       = '0;
    bus.sync_restart = 1'b0;
    resetn           = 1'b0;
    nxt;
    nxt;
    chk("rst_tick", bus.tick, 4'h0);
    chk("rst_clk", bus.clk_out, 4'h0);
    chk("rst_pend", bus.pending, 4'h0);

    // Default divide-by-2 on all channels
    resetn     = 1'b1;
    bus.enable = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      int m;
      logic [3:0] e;
      nxt;
      m = k - LAG;
      e = (m >= 0 && (m % 2) == 1) ? 4'hF : 4'h0;
      chk($sformatf("t1_tick_%0d", k), bus.tick, e);
      chk($sformatf("t1_clk_%0d", k), bus.clk_out, e);
      chk($sformatf("t1_pend_%0d", k), bus.pending, 4'h0);
    end

    // Odd divisor 5 on stopped channel 0
    bus.enable = 4'h0;
    bus.load   = 4'b0001;
    bus.div_in = 4'd5;
    nxt;
    chk("t2_off_tick", bus.tick, 4'h0);
    chk("t2_off_clk", bus.clk_out, (LAG != 0) ? 4'hF : 4'hE);
    bus.load   = 4'b0000;
    bus.enable = 4'b0001;
    for (int j = 1; j <= 9; j++) begin
      int m;
      logic t0, c0;
      nxt;
      m  = j - LAG;
      t0 = (m >= 0) && ((m % 5) == 4);
      c0 = (m >= 0) && ((m % 5) >= 2);
      chk($sformatf("t2_tick_%0d", j), bus.tick, {3'b000, t0});
      chk($sformatf("t2_clk_%0d", j), bus.clk_out, {3'b111, c0});
    end

`ifndef CLKDIV_REGOUT_EN
    // Shadow load on running channel 1 (D=4, then 6)
    bus.enable = 4'h0;
    bus.load   = 4'b0010;
    bus.div_in = 4'd4;
    nxt;
    chk("t3_setup_pend", bus.pending, 4'h0);
    bus.load   = 4'b0000;
    bus.enable = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      nxt;
      chk($sformatf("t3_tick_%0d", c), bus.tick, {2'b00, t3_tick[c], 1'b0});
      chk($sformatf("t3_clk_%0d", c), bus.clk_out, {2'b11, t3_clk[c], 1'b1});
      chk($sformatf("t3_pend_%0d", c), bus.pending, {2'b00, t3_pend[c], 1'b0});
      if (c == 1) begin
        bus.load   = 4'b0010;
        bus.div_in = 4'd6;
      end else begin
        bus.load = 4'b0000;
      end
    end

    // Divisor 0 clamps to 1 on channel 2
    bus.enable = 4'h0;
    bus.load   = 4'b0100;
    bus.div_in = 4'd0;
    nxt;
    chk("t4_d1_off_tick", bus.tick, 4'h0);
    chk("t4_d1_off_clk", bus.clk_out, 4'b1101);
    bus.load   = 4'b0000;
    bus.enable = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      nxt;
      chk($sformatf("t4_d1_tick_%0d", k), bus.tick, 4'b0100);
      chk($sformatf("t4_d1_clk_%0d", k), bus.clk_out, 4'b1101);
    end

    // Maximum divisor 15 on channel 3
    bus.enable = 4'h0;
    bus.load   = 4'b1000;
    bus.div_in = 4'd15;
    nxt;
    chk("t4_d15_off_clk", bus.clk_out, 4'b0101);
    bus.load   = 4'b0000;
    bus.enable = 4'b1000;
    for (int n = 1; n <= 16; n++) begin
      logic t3, c3;
      nxt;
      t3 = ((n % 15) == 14);
      c3 = ((n % 15) >= 7);
      chk($sformatf("t4_d15_tick_%0d", n), bus.tick, {t3, 3'b000});
      chk($sformatf("t4_d15_clk_%0d", n), bus.clk_out, {c3, 3'b101});
    end

    // Load on the wrap cycle: channel 0 sits at cnt=4 of 5
    bus.enable = 4'b0001;
    bus.load   = 4'b0001;
    bus.div_in = 4'd3;
    for (int q = 0; q <= 3; q++) begin
      logic t0, c0;
      nxt;
      bus.load = 4'b0000;
      t0 = (q == 2);
      c0 = (q == 1) || (q == 2);
      chk($sformatf("t5_wrap_tick_%0d", q), bus.tick, {3'b000, t0});
      chk($sformatf("t5_wrap_clk_%0d", q), bus.clk_out, {3'b010, c0});
      chk($sformatf("t5_wrap_pend_%0d", q), bus.pending, 4'h0);
    end

    // Sync restart applies a pending divisor
    bus.load   = 4'b0001;
    bus.div_in = 4'd7;
    nxt;
    chk("t5_sr_pend_before", bus.pending, 4'b0001);
    chk("t5_sr_clk_before", bus.clk_out, 4'b0101);
    bus.load         = 4'b0000;
    bus.sync_restart = 1'b1;
    nxt;
    chk("t5_sr_pend_after", bus.pending, 4'h0);
    chk("t5_sr_clk_after", bus.clk_out, 4'b0100);
    chk("t5_sr_tick_after", bus.tick, 4'h0);
    bus.sync_restart = 1'b0;
    for (int r = 1; r <= 7; r++) begin
      logic t0, c0;
      nxt;
      t0 = ((r % 7) == 6);
      c0 = ((r % 7) >= 3);
      chk($sformatf("t5_d7_tick_%0d", r), bus.tick, {3'b000, t0});
      chk($sformatf("t5_d7_clk_%0d", r), bus.clk_out, {3'b010, c0});
    end
`endif

    // Async reset at cnt=3 of 6 on channel 1, with a divisor pending
    bus.sync_restart = 1'b0;
    bus.enable       = 4'h0;
    bus.load         = 4'b0010;
    bus.div_in       = 4'd6;
    nxt;
    bus.load   = 4'b0000;
    bus.enable = 4'b0010;
    nxt;
    bus.load   = 4'b0010;
    bus.div_in = 4'd4;
    nxt;
    bus.load = 4'b0000;
    nxt;
    chk("t6_pend_before", bus.pending, 4'b0010);
    chk("t6_clk1_before", 32'(bus.clk_out[1]), (LAG != 0) ? 32'd0 : 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_tick", bus.tick, 4'h0);
    chk("t6_rst_clk", bus.clk_out, 4'h0);
    chk("t6_rst_pend", bus.pending, 4'h0);
    nxt;
    resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      int m;
      logic e;
      nxt;
      m = k - LAG;
      e = (m >= 0) && ((m % 2) == 1);
      chk($sformatf("t6_post_clk1_%0d", k), 32'(bus.clk_out[1]), 32'(e));
      chk($sformatf("t6_post_tick1_%0d", k), 32'(bus.tick[1]), 32'(e));
      chk($sformatf("t6_post_pend_%0d", k), bus.pending, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
